// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one memory command port between a write and a read requester,
// owning the circular row pointers and a per-transaction timeout.
module sdram_port_arbiter #(
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK_48MHZ,
    input  logic              RESET,
    input  logic              WR_REQ,
    input  logic [DATA_W-1:0] WR_DATA,
    output logic              WR_ACK,
    input  logic              RD_REQ,
    output logic              RD_VALID,
    output logic [DATA_W-1:0] DATA_READ,
    output logic [ADDR_W-1:0] ROW_WRITE,
    output logic [ADDR_W-1:0] ROW_READ,
    output logic [ADDR_W:0]   COUNT,
    output logic              EMPTY,
    output logic              FULL,
    output logic              MEM_CMD_VALID,
    output logic              MEM_CMD_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic              MEM_DONE,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              ERR
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [7:0]      TMO_LAST = 8'(TIMEOUT - 1);

    state_t          state_r;
    logic [ADDR_W:0] wp_r;
    logic [ADDR_W:0] rp_r;
    logic [7:0]      tmo_r;
    logic            last_grant_r;   // 1 = last grant was a write

    logic            wr_elig_s;
    logic            rd_elig_s;
    logic            grant_wr_s;
    logic [ADDR_W:0] wp_inc_s;
    logic [ADDR_W:0] rp_inc_s;
    logic [ADDR_W:0] cnt_after_wr_s;
    logic [ADDR_W:0] cnt_after_rd_s;
    logic            tmo_hit_s;

    assign wr_elig_s      = WR_REQ & ~FULL;
    assign rd_elig_s      = RD_REQ & ~EMPTY;
    // On contention the write wins only if the previous grant went to the read side.
    assign grant_wr_s     = wr_elig_s & (~rd_elig_s | ~last_grant_r);
    assign wp_inc_s       = wp_r + PTR_ONE;
    assign rp_inc_s       = rp_r + PTR_ONE;
    assign cnt_after_wr_s = wp_inc_s - rp_r;
    assign cnt_after_rd_s = wp_r - rp_inc_s;
    assign tmo_hit_s      = (tmo_r == TMO_LAST);

    assign ROW_WRITE = wp_r[ADDR_W-1:0];
    assign ROW_READ  = rp_r[ADDR_W-1:0];

    // Arbitration FSM with registered memory command, handshakes, pointers and occupancy.
    always_ff @(posedge CLK_48MHZ or negedge RESET) begin
        if (!RESET) begin
            state_r       <= IDLE;
            wp_r          <= '0;
            rp_r          <= '0;
            tmo_r         <= 8'd0;
            last_grant_r  <= 1'b0;
            COUNT         <= '0;
            EMPTY         <= 1'b1;
            FULL          <= 1'b0;
            MEM_CMD_VALID <= 1'b0;
            MEM_CMD_WRITE <= 1'b0;
            MEM_ADDR      <= '0;
            MEM_WDATA     <= '0;
            WR_ACK        <= 1'b0;
            RD_VALID      <= 1'b0;
            DATA_READ     <= '0;
            ERR           <= 1'b0;
        end else begin
            WR_ACK   <= 1'b0;
            RD_VALID <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (grant_wr_s) begin
                        state_r       <= WR_BUSY;
                        MEM_CMD_VALID <= 1'b1;
                        MEM_CMD_WRITE <= 1'b1;
                        MEM_ADDR      <= wp_r[ADDR_W-1:0];
                        MEM_WDATA     <= WR_DATA;
                        last_grant_r  <= 1'b1;
                        tmo_r         <= 8'd0;
                    end else if (rd_elig_s) begin
                        state_r       <= RD_BUSY;
                        MEM_CMD_VALID <= 1'b1;
                        MEM_CMD_WRITE <= 1'b0;
                        MEM_ADDR      <= rp_r[ADDR_W-1:0];
                        MEM_WDATA     <= WR_DATA;
                        last_grant_r  <= 1'b0;
                        tmo_r         <= 8'd0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WR_BUSY, RD_BUSY: begin
                    if (MEM_DONE) begin
                        state_r       <= GAP;
                        MEM_CMD_VALID <= 1'b0;
                        if (state_r == WR_BUSY) begin
                            WR_ACK <= 1'b1;
                            wp_r   <= wp_inc_s;
                            COUNT  <= cnt_after_wr_s;
                            EMPTY  <= (cnt_after_wr_s == '0);
                            FULL   <= (cnt_after_wr_s == DEPTH);
                        end else begin
                            RD_VALID  <= 1'b1;
                            DATA_READ <= MEM_RDATA;
                            rp_r      <= rp_inc_s;
                            COUNT     <= cnt_after_rd_s;
                            EMPTY     <= (cnt_after_rd_s == '0);
                            FULL      <= (cnt_after_rd_s == DEPTH);
                        end
                    end else if (tmo_hit_s) begin
                        // Abandon without ack; a still-pending request is re-arbitrated after GAP.
                        state_r       <= GAP;
                        MEM_CMD_VALID <= 1'b0;
                        ERR           <= 1'b1;
                    end else begin
                        tmo_r <= tmo_r + 8'd1;
                    end
                end
                GAP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r       <= IDLE;
                    MEM_CMD_VALID <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with an 8-row store and a 10-cycle timeout,
// acting as both requesters and as the memory controller.
module tb_sdram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        wr_req;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic        rd_valid;
    logic [15:0] data_read;
    logic [2:0]  row_write;
    logic [2:0]  row_read;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        mem_cmd_valid;
    logic        mem_cmd_write;
    logic [2:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        err;

    int n_checks;
    int n_errors;
    int seen;

    sdram_port_arbiter #(.ADDR_W(3), .DATA_W(16), .TIMEOUT(10)) dut (
        .CLK_48MHZ     (clk),
        .RESET         (rst_n),
        .WR_REQ        (wr_req),
        .WR_DATA       (wr_data),
        .WR_ACK        (wr_ack),
        .RD_REQ        (rd_req),
        .RD_VALID      (rd_valid),
        .DATA_READ     (data_read),
        .ROW_WRITE     (row_write),
        .ROW_READ      (row_read),
        .COUNT         (count),
        .EMPTY         (empty),
        .FULL          (full),
        .MEM_CMD_VALID (mem_cmd_valid),
        .MEM_CMD_WRITE (mem_cmd_write),
        .MEM_ADDR      (mem_addr),
        .MEM_WDATA     (mem_wdata),
        .MEM_DONE      (mem_done),
        .MEM_RDATA     (mem_rdata),
        .ERR           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_valid"}, 32'(mem_cmd_valid), 32'd0);
        chk({tag, "_write"}, 32'(mem_cmd_write), 32'd0);
        chk({tag, "_addr"},  32'(mem_addr),      32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata),     32'd0);
        chk({tag, "_wrack"}, 32'(wr_ack),        32'd0);
        chk({tag, "_rdval"}, 32'(rd_valid),      32'd0);
        chk({tag, "_data"},  32'(data_read),     32'd0);
        chk({tag, "_err"},   32'(err),           32'd0);
        chk({tag, "_count"}, 32'(count),         32'd0);
        chk({tag, "_empty"}, 32'(empty),         32'd1);
        chk({tag, "_full"},  32'(full),          32'd0);
        chk({tag, "_roww"},  32'(row_write),     32'd0);
        chk({tag, "_rowr"},  32'(row_read),      32'd0);
    endtask

    // Expects a grant at the very next edge, answers MEM_DONE after 'delay' busy cycles,
    // then steps through GAP so the caller is left just before the next IDLE edge.
    task automatic grant(input string tag, input logic is_wr, input logic [2:0] row,
                         input logic [15:0] wdata, input logic [15:0] rdata, input int delay);
        tick();
        chk({tag, "_valid"}, 32'(mem_cmd_valid), 32'd1);
        chk({tag, "_dir"},   32'(mem_cmd_write), 32'(is_wr));
        chk({tag, "_addr"},  32'(mem_addr),      32'(row));
        if (is_wr) chk({tag, "_wdata"}, 32'(mem_wdata), 32'(wdata));
        repeat (delay - 1) begin
            tick();
            chk({tag, "_hold"}, 32'(mem_cmd_valid), 32'd1);
        end
        mem_rdata = rdata;
        mem_done  = 1'b1;
        tick();
        mem_done  = 1'b0;
        mem_rdata = 16'h0000;
        chk({tag, "_wrack"}, 32'(wr_ack),        32'(is_wr));
        chk({tag, "_rdval"}, 32'(rd_valid),      32'(!is_wr));
        chk({tag, "_drop"},  32'(mem_cmd_valid), 32'd0);
        if (!is_wr) chk({tag, "_data"}, 32'(data_read), 32'(rdata));
        tick();
        chk({tag, "_pulse"}, 32'(wr_ack | rd_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        wr_req    = 1'b0;
        wr_data   = 16'h0000;
        rd_req    = 1'b0;
        mem_done  = 1'b0;
        mem_rdata = 16'h0000;
        tick();
        tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        // Single write, MEM_DONE three cycles after the command.
        wr_req  = 1'b1;
        wr_data = 16'h00FF;
        grant("w0", 1'b1, 3'd0, 16'h00FF, 16'h0000, 3);
        wr_req = 1'b0;
        chk("w0_roww",  32'(row_write), 32'd1);
        chk("w0_count", 32'(count),     32'd1);
        chk("w0_empty", 32'(empty),     32'd0);

        // Single read returning 0xFF00.
        rd_req = 1'b1;
        grant("r0", 1'b0, 3'd0, 16'h0000, 16'hFF00, 1);
        rd_req = 1'b0;
        chk("r0_count", 32'(count),     32'd0);
        chk("r0_empty", 32'(empty),     32'd1);
        chk("r0_rowr",  32'(row_read),  32'd1);
        chk("r0_hold",  32'(data_read), 32'hFF00);

        // Both requests held: W,R,W,R, one grant every three cycles.
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        wr_data = 16'h1111;
        grant("alt0", 1'b1, 3'd1, 16'h1111, 16'h0000, 1);
        grant("alt1", 1'b0, 3'd1, 16'h0000, 16'hA1A1, 1);
        wr_data = 16'h2222;
        grant("alt2", 1'b1, 3'd2, 16'h2222, 16'h0000, 1);
        grant("alt3", 1'b0, 3'd2, 16'h0000, 16'hA2A2, 1);
        wr_req = 1'b0;
        rd_req = 1'b0;

        // Read while empty is held off until a write lands.
        rd_req = 1'b1;
        seen   = 0;
        repeat (50) begin
            tick();
            if (mem_cmd_valid) seen++;
        end
        chk("empty_rd_hold", 32'(seen), 32'd0);
        wr_req  = 1'b1;
        wr_data = 16'h3333;
        grant("e_w", 1'b1, 3'd3, 16'h3333, 16'h0000, 1);
        wr_req = 1'b0;
        grant("e_r", 1'b0, 3'd3, 16'h0000, 16'hABCD, 1);
        rd_req = 1'b0;

        rst_n = 1'b0;
        tick();
        check_reset("rst2");
        rst_n = 1'b1;
        tick();

        // Fill all eight rows.
        for (int i = 0; i < 8; i++) begin
            wr_req  = 1'b1;
            wr_data = 16'h0100 + 16'(i);
            grant("fill", 1'b1, 3'(i), 16'h0100 + 16'(i), 16'h0000, 1);
            wr_req = 1'b0;
        end
        chk("full_flag",  32'(full),      32'd1);
        chk("full_count", 32'(count),     32'd8);
        chk("full_roww",  32'(row_write), 32'd0);
        chk("full_empty", 32'(empty),     32'd0);

        // Ninth write waits while full.
        wr_req  = 1'b1;
        wr_data = 16'h0900;
        seen    = 0;
        repeat (10) begin
            tick();
            if (mem_cmd_valid || wr_ack) seen++;
        end
        chk("full_wr_hold", 32'(seen), 32'd0);
        rd_req = 1'b1;
        grant("free", 1'b0, 3'd0, 16'h0000, 16'h0100, 1);
        rd_req = 1'b0;
        chk("free_count", 32'(count), 32'd7);
        chk("free_full",  32'(full),  32'd0);
        grant("w9", 1'b1, 3'd0, 16'h0900, 16'h0000, 1);
        wr_req = 1'b0;
        chk("w9_roww",  32'(row_write), 32'd1);
        chk("w9_count", 32'(count),     32'd8);
        chk("w9_full",  32'(full),      32'd1);

        // Contested grants with both sides eligible.
        rd_req = 1'b1;
        grant("pre_r1", 1'b0, 3'd1, 16'h0000, 16'h0101, 1);
        grant("pre_r2", 1'b0, 3'd2, 16'h0000, 16'h0102, 1);
        wr_req  = 1'b1;
        wr_data = 16'h0A00;
        grant("rr_w", 1'b1, 3'd1, 16'h0A00, 16'h0000, 1);
        grant("rr_r", 1'b0, 3'd3, 16'h0000, 16'h0103, 1);
        wr_data = 16'h0B00;
        grant("rr_w2", 1'b1, 3'd2, 16'h0B00, 16'h0000, 1);
        wr_req = 1'b0;
        rd_req = 1'b0;
        chk("rr_count", 32'(count),    32'd7);
        chk("rr_rowr",  32'(row_read), 32'd4);

        // Timeout: MEM_DONE withheld for ten busy cycles, then the retry completes.
        wr_req  = 1'b1;
        wr_data = 16'h5A5A;
        tick();
        chk("tmo_valid", 32'(mem_cmd_valid), 32'd1);
        chk("tmo_addr",  32'(mem_addr),      32'd3);
        repeat (9) tick();
        chk("tmo_late_valid", 32'(mem_cmd_valid), 32'd1);
        chk("tmo_late_err",   32'(err),           32'd0);
        tick();
        chk("tmo_drop",  32'(mem_cmd_valid), 32'd0);
        chk("tmo_err",   32'(err),           32'd1);
        chk("tmo_noack", 32'(wr_ack),        32'd0);
        chk("tmo_roww",  32'(row_write),     32'd3);
        chk("tmo_count", 32'(count),         32'd7);
        tick();
        grant("retry", 1'b1, 3'd3, 16'h5A5A, 16'h0000, 1);
        wr_req = 1'b0;
        chk("retry_err",   32'(err),   32'd1);
        chk("retry_count", 32'(count), 32'd8);

        // Reset asserted in the middle of a read transaction.
        rd_req = 1'b1;
        tick();
        chk("mid_valid", 32'(mem_cmd_valid), 32'd1);
        chk("mid_dir",   32'(mem_cmd_write), 32'd0);
        rst_n = 1'b0;
        #1;
        check_reset("mid_rst");
        rd_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid", 32'(mem_cmd_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
